// File: rtl/phase_controller.sv
// rtl/phase_controller.sv - 8-phase instruction sequencer with halt and retired-instruction counter (optional SINGLE_STEP_EN)
module phase_controller #(
    parameter int ICNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enab,
    input  logic [2:0]            opcode,
    input  logic                  zero,
    input  logic                  go,
`ifdef SINGLE_STEP_EN
    input  logic                  step,
`endif
    output logic [2:0]            phase,
    output logic                  sel,
    output logic                  rd,
    output logic                  ld_ir,
    output logic                  inc_pc,
    output logic                  halt,
    output logic                  ld_pc,
    output logic                  data_e,
    output logic                  ld_ac,
    output logic                  wr,
    output logic [ICNT_WIDTH-1:0] instr_cnt
);

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    phase_t state;
    logic   halted;
    logic   step_ok;
    logic   aluop;

    assign phase = state;
    assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);

    // In single-step builds phase 0 waits for a step pulse before starting an instruction.
`ifdef SINGLE_STEP_EN
    assign step_ok = (state != INST_ADDR) || step;
`else
    assign step_ok = 1'b1;
`endif

    // Phase sequencing, halt hold/release and retired-instruction counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INST_ADDR;
            halted    <= 1'b0;
            instr_cnt <= '0;
        end else if (enab) begin
            if (halted) begin
                // Halt parks at OP_FETCH; go releases straight into ALU_OP.
                if (go) begin
                    halted <= 1'b0;
                    state  <= ALU_OP;
                end
            end else if (step_ok) begin
                if (state == OP_ADDR && opcode == OP_HLT) begin
                    halted <= 1'b1;
                end
                if (state == STORE) begin
                    instr_cnt <= instr_cnt + 1'b1;
                end
                state <= phase_t'(state + 3'd1);
            end
        end
    end

    // Strobe decode from the current phase, opcode and zero flag; halted masks everything but halt.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        halt   = 1'b0;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        if (halted) begin
            halt = 1'b1;
        end else begin
            case (state)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                OP_FETCH: begin
                    rd = aluop;
                end
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (opcode == OP_JMP);
                    wr     = (opcode == OP_STO);
                    data_e = (opcode == OP_STO);
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_controller.sv
// tb/tb_phase_controller.sv - self-checking bench for phase_controller with behavioural model and random stimulus
module tb_phase_controller;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enab = 1'b0;
    logic [2:0]   opcode = 3'd0;
    logic         zero = 1'b0;
    logic         go = 1'b0;
`ifdef SINGLE_STEP_EN
    logic         step = 1'b1;
`endif
    logic [2:0]   phase;
    logic         sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
    logic [W-1:0] instr_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    phase_controller #(.ICNT_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .enab(enab), .opcode(opcode), .zero(zero), .go(go),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .phase(phase), .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .halt(halt),
        .ld_pc(ld_pc), .data_e(data_e), .ld_ac(ld_ac), .wr(wr), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: integer phase, halted flag, counter modulo 2^W.
    int m_ph = 0;
    bit m_halted = 0;
    int m_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph = 0; m_halted = 0; m_cnt = 0;
        end else if (enab) begin
            if (m_halted) begin
                if (go) begin m_halted = 0; m_ph = 6; end
            end else begin
                bit hold0;
                hold0 = 0;
`ifdef SINGLE_STEP_EN
                hold0 = (m_ph == 0) && !step;
`endif
                if (!hold0) begin
                    if (m_ph == 4 && opcode == 3'd0) m_halted = 1;
                    if (m_ph == 7) m_cnt = (m_cnt + 1) % (1 << W);
                    m_ph = (m_ph + 1) % 8;
                end
            end
        end
    end

    // Expected strobes {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr} straight from the phase table.
    function automatic logic [8:0] exp_strobes(int ph, bit hlt, logic [2:0] op, logic z);
        bit alu, s, r, li, ip, h, lp, de, la, w;
        alu = (op >= 3'd2 && op <= 3'd5);
        s = 0; r = 0; li = 0; ip = 0; h = 0; lp = 0; de = 0; la = 0; w = 0;
        if (hlt) return 9'b000010000;
        s  = (ph <= 3);
        r  = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        li = (ph == 2 || ph == 3);
        ip = (ph == 4) || (ph == 6 && op == 3'd1 && z);
        h  = (ph == 4 && op == 3'd0);
        lp = (ph >= 6 && op == 3'd7);
        de = (ph >= 6 && op == 3'd6);
        la = (ph == 7 && alu);
        w  = (ph == 7 && op == 3'd6);
        return {s, r, li, ip, h, lp, de, la, w};
    endfunction

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("model_phase", {29'd0, phase}, m_ph);
            chk("model_strobes", {23'd0, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr},
                {23'd0, exp_strobes(m_ph, m_halted, opcode, zero)});
            chk("model_cnt", {{(32-W){1'b0}}, instr_cnt}, m_cnt);
        end
    end

    task automatic clk1();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1; #1; rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_phase"}, {29'd0, phase}, 0);
        chk({tag, "_strobes"}, {23'd0, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr},
            32'h100);
        chk({tag, "_cnt"}, {{(32-W){1'b0}}, instr_cnt}, 0);
    endtask

    task automatic run_instr(input logic [2:0] op, input logic z,
                             output logic [7:0] rdm, output logic [7:0] ipm,
                             output logic [7:0] lam, output logic [7:0] dem,
                             output logic [7:0] wrm, output logic [7:0] lpm);
        opcode = op; zero = z; enab = 1'b1; go = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("seq_phase", {29'd0, phase}, i);
            rdm[i] = rd; ipm[i] = inc_pc; lam[i] = ld_ac;
            dem[i] = data_e; wrm[i] = wr; lpm[i] = ld_pc;
            clk1();
        end
    endtask

    logic [7:0] rdm, ipm, lam, dem, wrm, lpm;
    logic [W-1:0] cnt_before;

    initial begin
        rst = 1'b1; #12; rst = 1'b0;
        check_en = 1'b1;
        do_reset();
        chk_reset_state("reset");

        run_instr(3'd5, 1'b0, rdm, ipm, lam, dem, wrm, lpm);
        chk("lda_rd", rdm, 8'hEE);
        chk("lda_ld_ac", lam, 8'h80);
        chk("lda_cnt", {{(32-W){1'b0}}, instr_cnt}, 1);

        run_instr(3'd1, 1'b1, rdm, ipm, lam, dem, wrm, lpm);
        chk("skz1_inc_pc", ipm, 8'h50);
        chk("skz1_ld_ac", lam, 8'h00);
        run_instr(3'd1, 1'b0, rdm, ipm, lam, dem, wrm, lpm);
        chk("skz0_inc_pc", ipm, 8'h10);

        run_instr(3'd6, 1'b0, rdm, ipm, lam, dem, wrm, lpm);
        chk("sto_data_e", dem, 8'hC0);
        chk("sto_wr", wrm, 8'h80);
        chk("sto_rd", rdm, 8'h0E);
        run_instr(3'd7, 1'b0, rdm, ipm, lam, dem, wrm, lpm);
        chk("jmp_ld_pc", lpm, 8'hC0);
        chk("cnt_after5", {{(32-W){1'b0}}, instr_cnt}, 5);

        // Halt: decode at phase 4, park at 5, release with go.
        opcode = 3'd0; enab = 1'b1; go = 1'b0;
        for (int i = 0; i < 4; i++) clk1();
        chk("hlt_ph4_halt", {30'd0, halt, inc_pc}, 3);
        cnt_before = instr_cnt;
        clk1();
        for (int i = 0; i < 10; i++) clk1();
        chk("hlt_frozen_phase", {29'd0, phase}, 5);
        chk("hlt_frozen_strobes", {23'd0, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr},
            32'h010);
        chk("hlt_frozen_cnt", {{(32-W){1'b0}}, instr_cnt}, {{(32-W){1'b0}}, cnt_before});
        go = 1'b1; clk1(); go = 1'b0;
        chk("go_phase6", {29'd0, phase, halt}, {6'd0, 3'd6, 1'b0});
        clk1();
        chk("go_phase7", {29'd0, phase}, 7);
        clk1();
        chk("go_phase0", {29'd0, phase}, 0);
        chk("go_cnt", {{(32-W){1'b0}}, instr_cnt}, {{(32-W){1'b0}}, cnt_before + 1'b1});

        // enab=0 freezes at phase 3.
        opcode = 3'd2;
        for (int i = 0; i < 3; i++) clk1();
        enab = 1'b0;
        for (int i = 0; i < 5; i++) clk1();
        chk("enab_hold_phase", {29'd0, phase}, 3);
        enab = 1'b1;

        // Asynchronous reset mid-instruction, checked before any clock edge.
        clk1();
        rst = 1'b1; #1;
        chk_reset_state("async_rst");
        #1; rst = 1'b0;

        // Counter wrap at 2^W.
        do_reset();
        for (int k = 0; k < 15; k++) run_instr(3'd5, 1'b0, rdm, ipm, lam, dem, wrm, lpm);
        chk("cnt_15", {{(32-W){1'b0}}, instr_cnt}, 15);
        run_instr(3'd5, 1'b0, rdm, ipm, lam, dem, wrm, lpm);
        chk("cnt_wrap", {{(32-W){1'b0}}, instr_cnt}, 0);

`ifdef SINGLE_STEP_EN
        do_reset();
        step = 1'b0;
        for (int i = 0; i < 6; i++) clk1();
        chk("step_stuck", {29'd0, phase, sel}, {28'd0, 3'd0, 1'b1});
        step = 1'b1; clk1(); step = 1'b0;
        for (int i = 0; i < 12; i++) clk1();
        chk("step_one_phase", {29'd0, phase}, 0);
        chk("step_one_cnt", {{(32-W){1'b0}}, instr_cnt}, 1);
`endif

        // Randomized run against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk); #1;
            enab = ($urandom_range(0, 7) != 0);
            zero = $urandom_range(0, 1);
            go   = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) opcode = 3'($urandom_range(0, 7));
`ifdef SINGLE_STEP_EN
            step = ($urandom_range(0, 3) != 0);
`endif
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1; #2; rst = 1'b0;
            end
        end

        @(negedge clk); #1;
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
